// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer: FSM state encoding,
// default datapath sizes and the shift-count clamp.
package shift_sequencer_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Requests may ask for more shifts than the register holds; beyond WIDTH
  // the word is already all zeros, so the count saturates there.
  function automatic int unsigned clamp_count(input int unsigned cnt,
                                              input int unsigned width);
    return (cnt > width) ? width : cnt;
  endfunction

endpackage

// File: rtl/shift_sequencer_shift_core.sv
// Right-shift register with zero fill; streams each shifted-out bit on k
// with a one-cycle k_valid strobe.
module shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  output logic [WIDTH-1:0] y,
  output logic             k,
  output logic             k_valid
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      k       <= 1'b0;
      k_valid <= 1'b0;
    end else begin
      k_valid <= shift_en;
      if (load) begin
        y <= din;
      end else if (shift_en) begin
        y <= {1'b0, y[WIDTH-1:1]};
        k <= y[0];
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Round-robin arbiter and FSM sharing one right-shift datapath between two
// requesters; all outputs are registered.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  output logic [1:0]       gnt,
  output logic             owner,
  output logic [WIDTH-1:0] y,
  output logic             k,
  output logic             k_valid,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [CNT_W-1:0] rem;
  logic             last;

  logic             grant_any;
  logic             win;
  logic [WIDTH-1:0] sel_w;
  logic [CNT_W-1:0] sel_cnt;
  logic [CNT_W-1:0] load_rem;
  logic             shift_en;

  // A lone request always wins; on a tie the requester not served last wins.
  always_comb begin
    win = 1'b0;
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

  assign grant_any = (state == IDLE) && (req != 2'b00);
  assign sel_w     = win ? w1 : w0;
  assign sel_cnt   = win ? cnt1 : cnt0;
  assign load_rem  = CNT_W'(clamp_count(32'(sel_cnt), WIDTH));
  assign shift_en  = (state == SHIFT);

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_any) state_next = (load_rem != '0) ? SHIFT : DONE;
      SHIFT:   if (rem == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      last  <= 1'b1;
      gnt   <= 2'b00;
      owner <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      gnt   <= 2'b00;
      if (grant_any) begin
        gnt   <= win ? 2'b10 : 2'b01;
        owner <= win;
        last  <= win;
        rem   <= load_rem;
      end else if (shift_en) begin
        rem <= rem - CNT_W'(1);
      end
      // Registered from the next state so busy/done line up with the state.
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
    end
  end

  shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_any),
    .din      (sel_w),
    .shift_en (shift_en),
    .y        (y),
    .k        (k),
    .k_valid  (k_valid)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the driver pushes expected
// transactions from a round-robin model, a negedge monitor pops and checks.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] w0, w1;
  logic [2:0] cnt0, cnt1;
  logic [1:0] gnt;
  logic       owner;
  logic [3:0] y;
  logic       k, k_valid, busy, done;

  shift_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .w0(w0), .w1(w1), .cnt0(cnt0),
    .cnt1(cnt1), .gnt(gnt), .owner(owner), .y(y), .k(k),
    .k_valid(k_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       who;
    logic [3:0] w;
    int       n;
  } txn_t;

  txn_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   model_last = 1'b1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %s expected none", name, what);
  endtask

  // Reference model: one expected transaction per requester granted.
  function automatic void push_one(input int who, input logic [3:0] wv,
                                   input logic [2:0] cv);
    txn_t t;
    t.who = who;
    t.w   = wv;
    t.n   = (int'(cv) > 4) ? 4 : int'(cv);
    exp_q.push_back(t);
    model_last = (who == 1);
  endfunction

  function automatic void model_requests(input logic [1:0] r);
    int first;
    if (r == 2'b01) push_one(0, w0, cnt0);
    else if (r == 2'b10) push_one(1, w1, cnt1);
    else if (r == 2'b11) begin
      first = model_last ? 0 : 1;
      if (first == 0) begin push_one(0, w0, cnt0); push_one(1, w1, cnt1); end
      else begin push_one(1, w1, cnt1); push_one(0, w0, cnt0); end
    end
  endfunction

  // Monitor
  txn_t cur;
  bit   active = 1'b0;
  bit   check_idle = 1'b0;
  int   idx, busy_cnt;

  always @(negedge clk) begin
    if (rst) begin
      active     = 1'b0;
      check_idle = 1'b0;
    end else begin
      if (check_idle) begin
        check("busy_drop", 32'(busy), 0);
        check("kvalid_drop", 32'(k_valid), 0);
        check_idle = 1'b0;
      end
      if (gnt != 2'b00) begin
        if (exp_q.size() == 0) flag("unexpected_gnt", $sformatf("gnt=%b", gnt));
        else begin
          cur = exp_q.pop_front();
          check("gnt", 32'(gnt), (cur.who == 1) ? 2 : 1);
          check("owner", 32'(owner), cur.who);
          check("y_load", 32'(y), 32'(cur.w));
          check("busy_at_gnt", 32'(busy), 1);
          active   = 1'b1;
          idx      = 0;
          busy_cnt = 0;
        end
      end
      if (active && busy) busy_cnt++;
      if (k_valid) begin
        if (!active || idx >= cur.n) flag("unexpected_kvalid", $sformatf("k=%b", k));
        else begin
          check($sformatf("k[%0d]", idx), 32'(k), 32'(cur.w[idx]));
          idx++;
        end
      end
      if (done) begin
        if (!active) flag("unexpected_done", "done=1");
        else begin
          check("kvalid_count", idx, cur.n);
          check("y_final", 32'(y), 32'(cur.w >> cur.n));
          check("busy_cycles", busy_cnt, cur.n + 1);
          check("done_with_kvalid", 32'(k_valid), (cur.n > 0) ? 1 : 0);
          active     = 1'b0;
          check_idle = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_txn(input logic [1:0] r, input logic [3:0] w0v,
                         input logic [3:0] w1v, input logic [2:0] c0v,
                         input logic [2:0] c1v, input bit perturb);
    bit fin = 1'b0;
    w0 = w0v; w1 = w1v; cnt0 = c0v; cnt1 = c1v;
    req = r;
    model_requests(r);
    for (int i = 0; i < 60 && !fin; i++) begin
      step();
      if (gnt[0]) begin
        req[0] = 1'b0;
        if (perturb) begin w0 = ~w0; cnt0 = 3'($urandom_range(0, 7)); end
      end
      if (gnt[1]) begin
        req[1] = 1'b0;
        if (perturb) begin w1 = ~w1; cnt1 = 3'($urandom_range(0, 7)); end
      end
      fin = (req == 2'b00) && !busy && !active && (exp_q.size() == 0);
    end
    if (!fin) flag("txn_timeout", "still pending");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_owner"}, 32'(owner), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_k"}, 32'(k), 0);
    check({tag, "_kvalid"}, 32'(k_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic run_reset_test();
    bit seen = 1'b0;
    w0 = 4'($urandom); cnt0 = 3'd4; req = 2'b01;
    model_requests(req);
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = gnt[0];
    end
    if (!seen) flag("rst_gnt_timeout", "no gnt");
    req = 2'b00;
    step();                 // past the first shift edge
    rst = 1'b1;             // sampled at the second shift edge
    exp_q.delete();
    model_last = 1'b1;
    step();
    check_reset_values("midrst");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; w0 = '0; w1 = '0; cnt0 = '0; cnt1 = '0;
    step();
    step();
    check_reset_values("rst");
    rst = 1'b0;
    step();

    run_txn(2'b11, 4'b1111, 4'b0101, 3'd2, 3'd2, 1'b0);  // tie after reset
    run_txn(2'b01, 4'b1011, 4'b0000, 3'd3, 3'd0, 1'b0);  // single request
    run_txn(2'b10, 4'b0000, 4'b1001, 3'd0, 3'd0, 1'b0);  // zero count
    run_txn(2'b01, 4'b1111, 4'b0000, 3'd7, 3'd0, 1'b0);  // over-range
    run_reset_test();
    run_txn(2'b11, 4'b0110, 4'b1010, 3'd3, 3'd1, 1'b0);  // tie after reset again
    run_txn(2'b01, 4'b1101, 4'b0000, 3'd4, 3'd0, 1'b1);  // inputs change after grant

    for (int i = 0; i < 30; i++) begin
      run_txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom),
              3'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
